dmem_access_ctrl: RTL and testbench

Initiator-side controller that sits between the pipeline MEM stage and the word-addressed data memory, converting byte/halfword/word load and store requests into memory read/write handshakes. Sub-word stores are performed as a read-modify-write. Load data is returned lane-extracted and sign- or zero-extended. Misaligned accesses and unresponsive memory are reported as errors.

---
 rtl/dmem_access_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns byte/half/word loads and stores into
// word-wide memory handshakes, with read-modify-write for sub-word stores.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [1:0] SzByte     = 2'b00;
    localparam logic [1:0] SzHalf     = 2'b01;
    localparam logic [1:0] SzWord     = 2'b10;
    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    typedef enum logic [2:0] {StIdle, StRd, StWr, StRmwRd, StRmwWr, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic            sgn_q, sgn_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic [1:0]      resp_err_q, resp_err_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [9:0]      mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            misaligned;

    // Little-endian lane extraction followed by sign/zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SzByte:  return {{24{sgn & b[7]}}, b};
            SzHalf:  return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (size == SzByte) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        return r;
    endfunction

    assign misaligned = (req_size == 2'b11) ||
                        ((req_size == SzHalf) && req_addr[0]) ||
                        ((req_size == SzWord) && (req_addr[1:0] != 2'b00));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        off_d        = off_q;
        sgn_d        = sgn_q;
        wdata_d      = wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = ErrNone;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    sgn_d   = req_signed;
                    wdata_d = req_wdata[15:0];
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ErrAlign;
                    end else begin
                        mem_addr_d = {req_addr[9:2], 2'b00};
                        if (!req_we) begin
                            state_d    = StRd;
                            mem_read_d = 1'b1;
                        end else if (req_size == SzWord) begin
                            state_d     = StWr;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = StRmwRd;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            StRd, StRmwRd, StWr, StRmwWr: begin
                if (mem_done) begin
                    if (state_q == StRmwRd) begin
                        state_d     = StRmwWr;
                        cnt_d       = '0;
                        mem_write_d = 1'b1;
                        mem_wdata_d = store_merge(mem_rdata, off_q, size_q, wdata_q);
                    end else begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        if (state_q == StRd) begin
                            resp_rdata_d = load_extend(mem_rdata, off_q, size_q, sgn_q);
                        end
                    end
                end else if (cnt_q == CntLast) begin
                    // Drop the request; an RMW that times out on its read never writes.
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ErrTimeout;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_read_d  = (state_q == StRd) || (state_q == StRmwRd);
                    mem_write_d = (state_q == StWr) || (state_q == StRmwWr);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            sgn_q        <= 1'b0;
            wdata_q      <= 16'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'b00;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 10'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            off_q        <= off_d;
            sgn_q        <= sgn_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table driven through a scoreboard, a
// behavioural word memory with switchable response, and a mid-RMW reset.
module tb_dmem_access_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    dmem_access_ctrl #(.TIMEOUT(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        mem_on;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    logic both_seen = 1'b0;
    logic mem_en = 1'b1;
    exp_t sb_q[$];
    vec_t vq[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [9:0] addr, input logic [31:0] wdata,
                                input logic mem_on, input logic [31:0] exp_rdata,
                                input logic [1:0] exp_err, input int exp_lat,
                                input int exp_rd, input int exp_wr);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.mem_on = mem_on; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    // Behavioural memory: answers in the same cycle a request is seen, unless disabled.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h04] = 32'h0000_0004;
        mem[8'h30] = 32'h80FF_7F01;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            mem_done = 1'b0;
            if (reset_n && mem_en && (mem_read || mem_write)) begin
                mem_done = 1'b1;
                if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
                else mem_rdata = mem[mem_addr[9:2]];
            end
            if (mem_read) rd_cycles++;
            if (mem_write) wr_cycles++;
            if (mem_read && mem_write) both_seen = 1'b1;
        end
    end

    // Response monitor: every resp_valid must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp got rdata=%h err=%b want none",
                             resp_rdata, resp_err);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d_rdata", e.idx), resp_rdata, e.rdata);
                    chk($sformatf("v%0d_err", e.idx), {30'd0, resp_err}, {30'd0, e.err});
                    chk($sformatf("v%0d_latency", e.idx), 32'(cyc + 1 - e.acc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input int idx, input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        mem_en = v.mem_on;
        @(negedge clock);
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL v%0d_ready got 0 want 1", idx);
        end else begin
            req_valid  = 1'b1;
            req_we     = v.we;
            req_size   = v.size;
            req_signed = v.sgn;
            req_addr   = v.addr;
            req_wdata  = v.wdata;
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            e.idx   = idx;
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            e.lat   = v.exp_lat;
            e.acc   = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int idx);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d_no_resp got none want resp_valid", idx);
            sb_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int rd0, wr0;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 10'd0; req_wdata = 32'd0;

        //       we  size   sgn addr    wdata         on  rdata          err    lat rd  wr
        vq.push_back(mk(0, 2'd2, 0, 10'h010, 32'h0,        1, 32'h00000004, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd0, 1, 10'h0C3, 32'h0,        1, 32'hFFFFFF80, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd0, 0, 10'h0C2, 32'h0,        1, 32'h000000FF, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd1, 1, 10'h0C0, 32'h0,        1, 32'h00007F01, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd1, 1, 10'h0C2, 32'h0,        1, 32'hFFFF80FF, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd1, 0, 10'h0C2, 32'h0,        1, 32'h000080FF, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd0, 0, 10'h0C3, 32'h0,        1, 32'h00000080, 2'd0, 2,  1,  0));
        vq.push_back(mk(1, 2'd0, 0, 10'h0C1, 32'h000000AB, 1, 32'h00000000, 2'd0, 3,  1,  1));
        vq.push_back(mk(0, 2'd2, 0, 10'h0C0, 32'h0,        1, 32'h80FFAB01, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd2, 0, 10'h0C2, 32'h0,        1, 32'h00000000, 2'd1, 1,  0,  0));
        vq.push_back(mk(0, 2'd3, 0, 10'h0C0, 32'h0,        1, 32'h00000000, 2'd1, 1,  0,  0));
        vq.push_back(mk(1, 2'd1, 0, 10'h0C1, 32'h00001111, 1, 32'h00000000, 2'd1, 1,  0,  0));
        vq.push_back(mk(1, 2'd1, 0, 10'h0C2, 32'hFFFFBEEF, 1, 32'h00000000, 2'd0, 3,  1,  1));
        vq.push_back(mk(0, 2'd2, 0, 10'h0C0, 32'h0,        1, 32'hBEEFAB01, 2'd0, 2,  1,  0));
        vq.push_back(mk(1, 2'd2, 0, 10'h020, 32'h12345678, 1, 32'h00000000, 2'd0, 2,  0,  1));
        vq.push_back(mk(0, 2'd1, 0, 10'h022, 32'h0,        1, 32'h00001234, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd0, 1, 10'h021, 32'h0,        1, 32'h00000056, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd0, 1, 10'h020, 32'h0,        1, 32'h00000078, 2'd0, 2,  1,  0));
        vq.push_back(mk(1, 2'd0, 0, 10'h023, 32'h000000F0, 1, 32'h00000000, 2'd0, 3,  1,  1));
        vq.push_back(mk(0, 2'd2, 0, 10'h020, 32'h0,        1, 32'hF0345678, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd2, 0, 10'h010, 32'h0,        0, 32'h00000000, 2'd2, 17, 16, 0));
        vq.push_back(mk(1, 2'd0, 0, 10'h0C1, 32'h00000055, 0, 32'h00000000, 2'd2, 17, 16, 0));
        vq.push_back(mk(1, 2'd2, 0, 10'h0C0, 32'h0BADF00D, 0, 32'h00000000, 2'd2, 17, 0,  16));
        vq.push_back(mk(0, 2'd2, 0, 10'h010, 32'h0,        1, 32'h00000004, 2'd0, 2,  1,  0));
        vq.push_back(mk(0, 2'd2, 0, 10'h0C0, 32'h0,        1, 32'hBEEFAB01, 2'd0, 2,  1,  0));

        repeat (2) @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            rd0 = rd_cycles;
            wr0 = wr_cycles;
            send(i, vq[i]);
            drain(i);
            chk($sformatf("v%0d_rd_cycles", i), 32'(rd_cycles - rd0), 32'(vq[i].exp_rd));
            chk($sformatf("v%0d_wr_cycles", i), 32'(wr_cycles - wr0), 32'(vq[i].exp_wr));
        end

        // Reset while the write half of a byte RMW is in flight.
        mem_en = 1'b1;
        @(negedge clock);
        chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 10'h0C0; req_wdata = 32'h00000077;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rmw_wr_active", {30'd0, mem_read, mem_write}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rmw_rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rmw_rst_ready_low", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clock);
        chk("rmw_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rmw_rel_ready", {31'd0, req_ready}, 32'd1);
        send(100, mk(0, 2'd2, 0, 10'h0C0, 32'h0, 1, 32'hBEEFAB01, 2'd0, 2, 1, 0));
        drain(100);

        chk("rw_exclusive", {31'd0, both_seen}, 32'd0);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
